// File: rtl/key_pio_irq_if.sv
// Avalon-MM slave bus bundle for the key PIO: word address, read/write strobes
// and 32-bit data, with no waitrequest.
interface key_pio_irq_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/key_pio_irq.sv
// Push-button PIO: synchronizes and debounces active-low keys, latches press
// events into a W1C edge register and raises a masked level interrupt.
module key_pio_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_export,
  key_pio_irq_if.slave     bus,
  output logic             irq
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_meta_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_pressed;
  logic             w_unused;

  // Stage p0/p1: two-flop synchronizer on the asynchronous pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta_p0 <= '1;
      r_sync_p1 <= '1;
    end else begin
      r_meta_p0 <= key_export;
      r_sync_p1 <= r_meta_p0;
    end
  end

  // Debounce: a level is accepted only after it differs from stable for
  // DEBOUNCE_CYCLES consecutive cycles; w_fall flags the accepting edge.
  always_comb begin
    w_stable_nxt = r_stable;
    w_fall       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync_p1[i] != r_stable[i]) begin
        if (r_cnt[i] == LP_LAST) begin
          w_stable_nxt[i] = r_sync_p1[i];
          w_fall[i]       = r_stable[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '1;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign w_clr     = (bus.write && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_pressed = ~r_stable;
  assign w_unused  = ^bus.writedata[31:WIDTH];

  // Register file: a new press beats a same-cycle clear on the same bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_fall;
      r_irq  <= |(r_edge & r_mask);
      if (bus.write && bus.address == 2'd2) r_mask <= bus.writedata[WIDTH-1:0];
      if (bus.read) begin
        case (bus.address)
          2'd0:    r_readdata <= 32'(w_pressed);
          2'd2:    r_readdata <= 32'(r_mask);
          2'd3:    r_readdata <= 32'(r_edge);
          default: r_readdata <= '0;
        endcase
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_key_pio_irq.sv
// Bench for key_pio_irq: register table, directed debounce/irq/reset sequences
// and random traffic checked every cycle against a behavioural model.
module tb_key_pio_irq;
  localparam int W  = 4;
  localparam int DB = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         irq;
  logic [W-1:0] kv;

  key_pio_irq_if bus_if();

  key_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .key_export(kv), .bus(bus_if), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pins reach the debouncer two cycles late; a level is
  // accepted once it has differed from the accepted level for DB cycles.
  logic [W-1:0] m_pin_d1, m_pin_d2, m_stable, m_mask, m_edge;
  int           m_diff_run [W];
  logic [31:0]  m_rd;
  logic         m_irq;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] a, logic [31:0] wd,
                              logic [31:0] e_rd, logic e_irq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.exp_rd = e_rd; v.exp_irq = e_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] press;
    if (reset) begin
      m_pin_d1 = '1; m_pin_d2 = '1; m_stable = '1;
      m_mask = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) m_diff_run[i] = 0;
    end else begin
      m_irq = |(m_edge & m_mask);
      if (bus_if.read) begin
        case (bus_if.address)
          2'd0:    m_rd = {28'd0, ~m_stable};
          2'd2:    m_rd = {28'd0, m_mask};
          2'd3:    m_rd = {28'd0, m_edge};
          default: m_rd = 32'd0;
        endcase
      end
      press = '0;
      for (int i = 0; i < W; i++) begin
        if (m_pin_d2[i] != m_stable[i]) begin
          m_diff_run[i] = m_diff_run[i] + 1;
          if (m_diff_run[i] == DB) begin
            press[i]      = m_stable[i];
            m_stable[i]   = m_pin_d2[i];
            m_diff_run[i] = 0;
          end
        end else begin
          m_diff_run[i] = 0;
        end
      end
      for (int i = 0; i < W; i++) begin
        if (press[i]) m_edge[i] = 1'b1;
        else if (bus_if.write && bus_if.address == 2'd3 && bus_if.writedata[i]) m_edge[i] = 1'b0;
      end
      if (bus_if.write && bus_if.address == 2'd2) m_mask = bus_if.writedata[W-1:0];
      m_pin_d2 = m_pin_d1;
      m_pin_d1 = kv;
    end
  endtask

  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [1:0] a, input logic [31:0] wd);
    reset            = rst;
    bus_if.read      = rd;
    bus_if.write     = wr;
    bus_if.address   = a;
    bus_if.writedata = wd;
    @(posedge clk);
    model_edge();
    #1;
    check("model_readdata", bus_if.readdata, m_rd);
    check("model_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    kv = '1;
    for (int i = 0; i < W; i++) m_diff_run[i] = 0;
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    check("reset_readdata", bus_if.readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);

    vecs[0]  = mk(1, 0, 2'd0, 32'd0,         32'd0, 0);
    vecs[1]  = mk(1, 0, 2'd1, 32'd0,         32'd0, 0);
    vecs[2]  = mk(1, 0, 2'd2, 32'd0,         32'd0, 0);
    vecs[3]  = mk(1, 0, 2'd3, 32'd0,         32'd0, 0);
    vecs[4]  = mk(0, 1, 2'd2, 32'hFFFF_FFF5, 32'd0, 0);
    vecs[5]  = mk(1, 0, 2'd2, 32'd0,         32'h5, 0);
    vecs[6]  = mk(0, 1, 2'd1, 32'hFFFF_FFFF, 32'h5, 0);
    vecs[7]  = mk(1, 0, 2'd1, 32'd0,         32'd0, 0);
    vecs[8]  = mk(0, 1, 2'd0, 32'h0000_000F, 32'd0, 0);
    vecs[9]  = mk(1, 0, 2'd0, 32'd0,         32'd0, 0);
    vecs[10] = mk(0, 1, 2'd3, 32'h0000_000F, 32'd0, 0);
    vecs[11] = mk(1, 0, 2'd3, 32'd0,         32'd0, 0);
    vecs[12] = mk(0, 0, 2'd0, 32'd0,         32'd0, 0);
    vecs[13] = mk(0, 1, 2'd2, 32'd0,         32'd0, 0);
    vecs[14] = mk(1, 0, 2'd2, 32'd0,         32'd0, 0);
    for (int v = 0; v < 15; v++) begin
      step(1'b0, vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].wd);
      check($sformatf("vec%0d_readdata", v), bus_if.readdata, vecs[v].exp_rd);
      check($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
    end

    // KEY[1] press: DATA flips exactly DB+2 cycles after the pin change
    kv = 4'b1101;
    for (int s = 1; s <= 11; s++) begin
      rd(2'd0);
      if (s == 10) check("key1_data_before", bus_if.readdata, 32'd0);
      if (s == 11) check("key1_data_after", bus_if.readdata, 32'h2);
    end
    rd(2'd3);
    check("key1_edge", bus_if.readdata, 32'h2);
    check("key1_irq_masked", {31'd0, irq}, 32'd0);

    wr(2'd2, 32'h2);
    check("unmask_irq_same", {31'd0, irq}, 32'd0);
    idle(1);
    check("unmask_irq_next", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h2);
    check("clear_irq_same", {31'd0, irq}, 32'd1);
    rd(2'd3);
    check("clear_edge", bus_if.readdata, 32'd0);
    check("clear_irq_next", {31'd0, irq}, 32'd0);

    kv = 4'b1111;
    idle(12);
    rd(2'd3);
    check("release_no_event", bus_if.readdata, 32'd0);
    rd(2'd0);
    check("release_data", bus_if.readdata, 32'd0);

    // Glitch train on KEY[0]: 7 low, 1 high, three times
    for (int g = 0; g < 3; g++) begin
      kv = 4'b1110; idle(7);
      kv = 4'b1111; idle(1);
    end
    idle(10);
    rd(2'd0);
    check("glitch_data", bus_if.readdata, 32'd0);
    rd(2'd3);
    check("glitch_edge", bus_if.readdata, 32'd0);
    check("glitch_irq", {31'd0, irq}, 32'd0);
    kv = 4'b1110; idle(8);
    kv = 4'b1111; idle(12);
    rd(2'd3);
    check("hold8_edge", bus_if.readdata, 32'h1);
    wr(2'd3, 32'hF);

    // KEY[3] acceptance lands on the same edge as an EDGE clear
    kv = 4'b0111;
    idle(9);
    wr(2'd3, 32'h8);
    rd(2'd3);
    check("set_wins", bus_if.readdata, 32'h8);
    kv = 4'b1111;
    idle(12);
    wr(2'd3, 32'hF);
    rd(2'd3);
    check("set_wins_cleared", bus_if.readdata, 32'd0);

    // KEY[2] held through a one-cycle reset
    kv = 4'b1011;
    idle(12);
    wr(2'd2, 32'h4);
    idle(1);
    check("key2_irq", {31'd0, irq}, 32'd1);
    rd(2'd3);
    check("key2_edge", bus_if.readdata, 32'h4);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    check("midreset_readdata", bus_if.readdata, 32'd0);
    check("midreset_irq", {31'd0, irq}, 32'd0);
    rd(2'd0);
    check("postreset_data", bus_if.readdata, 32'd0);
    rd(2'd1);
    check("postreset_reserved", bus_if.readdata, 32'd0);
    rd(2'd2);
    check("postreset_mask", bus_if.readdata, 32'd0);
    for (int s = 4; s <= 11; s++) begin
      rd(2'd3);
      if (s == 10) check("postreset_edge_before", bus_if.readdata, 32'd0);
      if (s == 11) check("postreset_edge_after", bus_if.readdata, 32'h4);
    end
    rd(2'd1);
    check("reserved_late", bus_if.readdata, 32'd0);
    rd(2'd0);
    check("postreset_pressed", bus_if.readdata, 32'h4);
    check("postreset_irq", {31'd0, irq}, 32'd0);
    kv = 4'b1111;
    idle(12);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int op;
      for (int b = 0; b < W; b++)
        if ($urandom_range(9) == 0) kv[b] = ~kv[b];
      op = int'($urandom_range(9));
      case (op)
        0, 1, 2: step(1'b0, 1'b1, 1'b0, 2'($urandom_range(3)), 32'd0);
        3:       step(1'b0, 1'b0, 1'b1, 2'd2, $urandom);
        4:       step(1'b0, 1'b0, 1'b1, 2'd3, $urandom);
        5:       step(1'b0, 1'b0, 1'b1, 2'($urandom_range(1)), $urandom);
        6:       step($urandom_range(39) == 0, 1'b0, 1'b0, 2'd0, 32'd0);
        default: idle(1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
